// File: rtl/pipe_field.sv
// pipe_field: scrolling pipe slots with BCD score and registered collision.
// Optional PIPE_FIELD_SPEEDUP_EN: scroll step grows with the score tens digit.

module pipe_field #(
    parameter int NUM_PIPES    = 3,
    parameter int SPEED        = 5,
    parameter int SPAWN_PERIOD = 64,
    parameter int SPAWN_Y      = 480,
    parameter int GAP_BASE     = 420,
    parameter int SCORE_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          new_frame,
    input  logic                          start,
    input  logic                          freeze,
    input  logic                          clear,
    input  logic [7:0]                    random,
    input  logic signed [15:0]            bird_x,
    input  logic signed [15:0]            bird_y,
    output logic signed [16*NUM_PIPES-1:0] pipe_x,
    output logic signed [16*NUM_PIPES-1:0] pipe_y,
    output logic [NUM_PIPES-1:0]          pipe_valid,
    output logic [4*SCORE_DIGITS-1:0]     score_bcd,
    output logic                          score_pulse,
    output logic                          hit,
    output logic                          score_max
);

    localparam int CW = $clog2(SPAWN_PERIOD);
    localparam logic [4*SCORE_DIGITS-1:0] ALL9 = {SCORE_DIGITS{4'h9}};
    localparam logic [15:0] GAP = 16'(GAP_BASE);

    typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_FROZEN} state_t;

    state_t                    state, state_nxt;
    logic signed [15:0]        px [NUM_PIPES];
    logic signed [15:0]        py [NUM_PIPES];
    logic signed [15:0]        my [NUM_PIPES];
    logic [NUM_PIPES-1:0]      valid;
    logic [4*SCORE_DIGITS-1:0] score, score_inc;
    logic [CW-1:0]             cnt;
    logic                      hit_q, pulse_q, spawn;
    logic                      score_hit, hit_any, all9, bcd_c;
    logic signed [16:0]        step, dx, dy, dw;

    assign all9  = (score == ALL9);
    assign spawn = (cnt == CW'(SPAWN_PERIOD - 1));

`ifdef PIPE_FIELD_SPEEDUP_EN
    logic [3:0] tens;
    if (SCORE_DIGITS > 1) begin : g_tens
        assign tens = score[7:4];
    end else begin : g_no_tens
        assign tens = 4'd0;
    end

    always_comb begin
        step = 17'(SPEED) + 17'(tens);
        if (step > 17'(2 * SPEED))
            step = 17'(2 * SPEED);
    end
`else
    assign step = 17'(SPEED);
`endif

    always_comb begin
        for (int k = 0; k < NUM_PIPES; k++)
            my[k] = valid[k] ? py[k] - step[15:0] : py[k];
    end

    // BCD +1, ripple carry from digit 0
    always_comb begin
        score_inc = score;
        bcd_c     = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (bcd_c && score[4*i +: 4] == 4'd9) begin
                score_inc[4*i +: 4] = 4'd0;
            end else if (bcd_c) begin
                score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
                bcd_c = 1'b0;
            end
        end
    end

    always_comb begin
        score_hit = 1'b0;
        hit_any   = all9 || (bird_x <= 16'sd104);
        dx = '0;
        dy = '0;
        dw = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            dx = $signed({px[k][15], px[k]}) - $signed({bird_x[15], bird_x});
            dy = $signed({py[k][15], py[k]}) - $signed({bird_y[15], bird_y});
            dw = dy + 17'sd40;
            if (valid[k]) begin
                if (dw >= 17'sd0 && dw < step)
                    score_hit = 1'b1;
                if (dy >= -17'sd96 && dy <= 17'sd55 &&
                    (dx > 17'sd220 || dx < 17'sd80))
                    hit_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_frame) begin
            if (clear) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:   if (start) state_nxt = S_SCROLL;
                    S_SCROLL: if (freeze || hit_q) state_nxt = S_FROZEN;
                    S_FROZEN: state_nxt = S_FROZEN;
                    default:  state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Entering or sitting in IDLE reloads the layout; FROZEN holds everything
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                px[k] <= '0;
                py[k] <= '0;
            end
            valid   <= '0;
            score   <= '0;
            cnt     <= '0;
            hit_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (new_frame) begin
                if (state == S_IDLE || state_nxt == S_IDLE) begin
                    for (int k = 0; k < NUM_PIPES; k++) begin
                        px[k] <= 16'(680 - 90 * k);
                        py[k] <= -16'sd120;
                    end
                    valid <= '0;
                    score <= '0;
                    cnt   <= '0;
                    hit_q <= 1'b0;
                end else if (state == S_SCROLL && state_nxt == S_SCROLL) begin
                    cnt   <= spawn ? '0 : cnt + CW'(1);
                    hit_q <= hit_any;
                    if (score_hit && !all9) begin
                        score   <= score_inc;
                        pulse_q <= 1'b1;
                    end
                    if (spawn) begin
                        for (int k = 0; k < NUM_PIPES - 1; k++) begin
                            px[k] <= px[k+1];
                            py[k] <= my[k+1];
                        end
                        px[NUM_PIPES-1] <= GAP + {8'd0, random};
                        py[NUM_PIPES-1] <= 16'(SPAWN_Y);
                        valid <= {1'b1, valid[NUM_PIPES-1:1]};
                    end else begin
                        for (int k = 0; k < NUM_PIPES; k++)
                            py[k] <= my[k];
                    end
                end
            end
        end
    end

    always_comb begin
        pipe_x = '0;
        pipe_y = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            pipe_x[16*k +: 16] = px[k];
            pipe_y[16*k +: 16] = py[k];
        end
        pipe_valid  = valid;
        score_bcd   = score;
        score_pulse = pulse_q;
        hit         = hit_q;
        score_max   = all9;
    end

endmodule
